// File: rtl/tick_scheduler.sv
// tick_scheduler: shares the divider tick among NUM_REQ job slots.
// Optional TICK_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
module tick_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_tick,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] i_req_len,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_busy,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_div_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]         st_q    [NUM_REQ];
  logic [CNT_W-1:0]   rem_q   [NUM_REQ];
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               div_q;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] len_zero;
  logic [NUM_REQ-1:0] last;
  logic [NUM_REQ-1:0] tick_win;
  logic               win_any;
  logic [PTR_W-1:0]   win_idx;

  // Decode slot state into flat vectors and qualify handshakes
  always_comb begin
    active   = '0;
    accept   = '0;
    len_zero = '0;
    last     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      active[i]   = (st_q[i] == S_ACTIVE);
      len_zero[i] = (i_req_len[i*CNT_W +: CNT_W] == '0);
      accept[i]   = i_req_valid[i] & ~active[i];
      last[i]     = tick_win[i] &
                    (rem_q[i] == CNT_W'(1));
    end
  end

`ifdef TICK_SCHED_FIXED_PRIO_EN

  // Lowest-index active slot takes the tick
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_any = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end

`else

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Search upward from ptr, wrapping, for the first active slot
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!win_any && active[idx]) begin
        win_any = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Rotate pointer past each winner; dropped ticks leave it alone
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q <= '0;
    end else if (i_tick && win_any) begin
      if (win_idx == PTR_W'(NUM_REQ - 1))
        ptr_q <= '0;
      else
        ptr_q <= win_idx + PTR_W'(1);
    end
  end

`endif

  // One-hot tick owner for this cycle, empty when no tick or no job
  always_comb begin
    tick_win = '0;
    if (i_tick && win_any)
      tick_win = NUM_REQ'(1) << win_idx;
  end

  // Per-slot job state: load on accept, count down on granted ticks
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        st_q[i]  <= S_IDLE;
        rem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i] && !len_zero[i]) begin
          st_q[i]  <= S_ACTIVE;
          rem_q[i] <= i_req_len[i*CNT_W +: CNT_W];
        end else if (tick_win[i]) begin
          rem_q[i] <= rem_q[i] - CNT_W'(1);
          if (last[i])
            st_q[i] <= S_IDLE;
        end
      end
    end
  end

  // Registered grant/done strobes and sticky divider enable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grant_q <= '0;
      done_q  <= '0;
      div_q   <= 1'b0;
    end else begin
      grant_q <= tick_win;
      done_q  <= last | (accept & len_zero);
      if (|accept)
        div_q <= 1'b1;
    end
  end

  assign o_req_ready = ~active;
  assign o_busy      = active;
  assign o_grant     = grant_q;
  assign o_done      = done_q;
  assign o_div_ready = div_q;

endmodule
